// File: rtl/fll_cfg_pkg.sv
// Shared types and constants for the FLL configuration responder:
// FSM states, register addresses and the CFG1/CFG2 field layouts.
package fll_cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_ACKED
  } state_t;

  localparam logic [1:0] ADDR_STATUS = 2'd0;
  localparam logic [1:0] ADDR_CFG1   = 2'd1;
  localparam logic [1:0] ADDR_CFG2   = 2'd2;
  localparam logic [1:0] ADDR_INTEG  = 2'd3;

  localparam int INTEG_W = 26;

  typedef struct packed {
    logic        open_loop;
    logic [10:0] rsvd;
    logic [3:0]  div;
    logic [15:0] mult;
  } cfg1_t;

  typedef struct packed {
    logic [19:0] rsvd_hi;
    logic [3:0]  tol;
    logic [3:0]  rsvd_lo;
    logic [3:0]  gain;
  } cfg2_t;

  localparam logic [31:0]        CFG1_RST_DEFAULT  = 32'h0000_05F5;
  localparam logic [31:0]        CFG2_RST_DEFAULT  = 32'h0000_0247;
  localparam logic [INTEG_W-1:0] INTEG_RST_DEFAULT = '0;

endpackage

// File: rtl/fll_lock_detect.sv
// Lock detector: counts consecutive in-tolerance frequency measurements
// and raises lock once LOCK_CYCLES of them have been seen.
module fll_lock_detect #(
  parameter int LOCK_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        meas_valid,
  input  logic [15:0] meas_cnt,
  input  logic [15:0] cfg_mult,
  input  logic [3:0]  cfg_tol,
  input  logic        open_loop,
  input  logic        clear,
  output logic        lock
);

  localparam int CW = $clog2(LOCK_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(LOCK_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          lock_q, lock_d;
  logic [16:0]   meas_ext, mult_ext, diff;
  logic          in_tol;

  // Evaluation against the current cfg_mult; a concurrent clear overrides it.
  always_comb begin
    meas_ext = {1'b0, meas_cnt};
    mult_ext = {1'b0, cfg_mult};
    diff     = (meas_ext >= mult_ext) ? (meas_ext - mult_ext) : (mult_ext - meas_ext);
    in_tol   = (diff <= {13'd0, cfg_tol});
    cnt_d    = cnt_q;
    lock_d   = lock_q;
    if (meas_valid) begin
      if (in_tol) begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
        lock_d = (cnt_d == CNT_MAX);
      end else begin
        cnt_d  = '0;
        lock_d = 1'b0;
      end
    end
    if (clear) begin
      cnt_d  = '0;
      lock_d = 1'b0;
    end
    if (open_loop) lock_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      lock_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      lock_q <= lock_d;
    end
  end

  assign lock = lock_q;

endmodule

// File: rtl/fll_cfg_responder.sv
// FLL-side responder of the four-phase configuration handshake: synchronises
// req, serves register reads/writes and exports configuration and lock.
module fll_cfg_responder
  import fll_cfg_pkg::*;
#(
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] CFG1_RST    = CFG1_RST_DEFAULT,
  parameter logic [31:0] CFG2_RST    = CFG2_RST_DEFAULT,
  parameter int          LOCK_CYCLES = 8
) (
  input  logic                HCLK,
  input  logic                HRESET,
  input  logic                req,
  input  logic                wrn,
  input  logic [1:0]          add,
  input  logic [31:0]         data,
  output logic                ack,
  output logic [31:0]         r_data,
  input  logic [15:0]         meas_cnt,
  input  logic                meas_valid,
  output logic                lock,
  output logic [15:0]         cfg_mult,
  output logic [3:0]          cfg_div,
  output logic                cfg_open_loop,
  output logic [3:0]          cfg_gain,
  output logic [3:0]          cfg_tol,
  output logic [INTEG_W-1:0]  cfg_integ,
  output logic                integ_load,
  output logic                cfg_upd
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  state_t                 state_q, state_d;
  logic                   ack_q, ack_d;
  logic [31:0]            r_data_q, r_data_d;
  cfg1_t                  cfg1_q, cfg1_d;
  cfg2_t                  cfg2_q, cfg2_d;
  logic [INTEG_W-1:0]     integ_q, integ_d;
  logic                   integ_load_q, integ_load_d;
  logic                   cfg_upd_q, cfg_upd_d;
  logic [15:0]            last_meas_q, last_meas_d;
  logic                   req_s, req_arrive, cfg1_wr, lock_w;
  logic [31:0]            status_word;

  assign req_s = sync_q[SYNC_STAGES-1];
  // Entry from IDLE coincides with the last synchroniser stage capturing,
  // which keeps req-to-ack at SYNC_STAGES+1 edges.
  assign req_arrive  = sync_q[SYNC_STAGES-2];
  assign status_word = {15'd0, lock_w, last_meas_q};

  always_comb begin
    sync_d       = {sync_q[SYNC_STAGES-2:0], req};
    state_d      = state_q;
    ack_d        = ack_q;
    r_data_d     = r_data_q;
    cfg1_d       = cfg1_q;
    cfg2_d       = cfg2_q;
    integ_d      = integ_q;
    integ_load_d = 1'b0;
    cfg_upd_d    = 1'b0;
    cfg1_wr      = 1'b0;
    last_meas_d  = meas_valid ? meas_cnt : last_meas_q;
    unique case (state_q)
      ST_IDLE: begin
        ack_d = 1'b0;
        if (req_arrive) state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        state_d = ST_ACKED;
        ack_d   = 1'b1;
        if (wrn) begin
          unique case (add)
            ADDR_STATUS: r_data_d = status_word;
            ADDR_CFG1:   r_data_d = cfg1_q;
            ADDR_CFG2:   r_data_d = cfg2_q;
            default:     r_data_d = {{(32-INTEG_W){1'b0}}, integ_q};
          endcase
        end else begin
          unique case (add)
            ADDR_CFG1: begin
              cfg1_d    = data;
              cfg1_wr   = 1'b1;
              cfg_upd_d = 1'b1;
            end
            ADDR_CFG2: begin
              cfg2_d    = data;
              cfg_upd_d = 1'b1;
            end
            ADDR_INTEG: begin
              integ_d      = data[INTEG_W-1:0];
              integ_load_d = 1'b1;
            end
            default: ;
          endcase
        end
      end
      ST_ACKED: begin
        if (!req_s) begin
          state_d = ST_IDLE;
          ack_d   = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ack_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      sync_q       <= '0;
      state_q      <= ST_IDLE;
      ack_q        <= 1'b0;
      r_data_q     <= '0;
      cfg1_q       <= cfg1_t'(CFG1_RST);
      cfg2_q       <= cfg2_t'(CFG2_RST);
      integ_q      <= INTEG_RST_DEFAULT;
      integ_load_q <= 1'b0;
      cfg_upd_q    <= 1'b0;
      last_meas_q  <= '0;
    end else begin
      sync_q       <= sync_d;
      state_q      <= state_d;
      ack_q        <= ack_d;
      r_data_q     <= r_data_d;
      cfg1_q       <= cfg1_d;
      cfg2_q       <= cfg2_d;
      integ_q      <= integ_d;
      integ_load_q <= integ_load_d;
      cfg_upd_q    <= cfg_upd_d;
      last_meas_q  <= last_meas_d;
    end
  end

  fll_lock_detect #(
    .LOCK_CYCLES(LOCK_CYCLES)
  ) u_lock_detect (
    .clk       (HCLK),
    .rst       (HRESET),
    .meas_valid(meas_valid),
    .meas_cnt  (meas_cnt),
    .cfg_mult  (cfg1_q.mult),
    .cfg_tol   (cfg2_q.tol),
    .open_loop (cfg1_q.open_loop),
    .clear     (cfg1_wr),
    .lock      (lock_w)
  );

  assign ack           = ack_q;
  assign r_data        = r_data_q;
  assign lock          = lock_w;
  assign cfg_mult      = cfg1_q.mult;
  assign cfg_div       = cfg1_q.div;
  assign cfg_open_loop = cfg1_q.open_loop;
  assign cfg_gain      = cfg2_q.gain;
  assign cfg_tol       = cfg2_q.tol;
  assign cfg_integ     = integ_q;
  assign integ_load    = integ_load_q;
  assign cfg_upd       = cfg_upd_q;

endmodule

// File: tb/tb_fll_cfg_responder.sv
// Directed self-checking bench for fll_cfg_responder: handshake timing,
// register map, pulses, lock detection and reset during a transfer.
module tb_fll_cfg_responder;

  logic        HCLK = 1'b0;
  logic        HRESET, req, wrn, meas_valid;
  logic [1:0]  add;
  logic [31:0] data;
  logic [15:0] meas_cnt;
  logic        ack, lock, cfg_open_loop, integ_load, cfg_upd;
  logic [31:0] r_data;
  logic [15:0] cfg_mult;
  logic [3:0]  cfg_div, cfg_gain, cfg_tol;
  logic [25:0] cfg_integ;

  int checks = 0;
  int failures = 0;
  int upd_seen = 0;
  int integ_seen = 0;

  fll_cfg_responder dut (
    .HCLK         (HCLK),
    .HRESET       (HRESET),
    .req          (req),
    .wrn          (wrn),
    .add          (add),
    .data         (data),
    .ack          (ack),
    .r_data       (r_data),
    .meas_cnt     (meas_cnt),
    .meas_valid   (meas_valid),
    .lock         (lock),
    .cfg_mult     (cfg_mult),
    .cfg_div      (cfg_div),
    .cfg_open_loop(cfg_open_loop),
    .cfg_gain     (cfg_gain),
    .cfg_tol      (cfg_tol),
    .cfg_integ    (cfg_integ),
    .integ_load   (integ_load),
    .cfg_upd      (cfg_upd)
  );

  always #5 HCLK = ~HCLK;

  // Pulse counters sampled mid-cycle; tests compare before/after snapshots.
  always @(negedge HCLK) begin
    if (cfg_upd) upd_seen++;
    if (integ_load) integ_seen++;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Counts rising edges until ack reaches the given level; -1 on timeout.
  task automatic waitAck(input logic level, output int n);
    n = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge HCLK);
      #1;
      if (ack === level) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic applyStimulus(input logic w, input logic [1:0] a, input logic [31:0] d,
                               output logic [31:0] rd, output int rise, output int fall);
    @(negedge HCLK);
    wrn = w; add = a; data = d; req = 1'b1;
    waitAck(1'b1, rise);
    rd = r_data;
    @(negedge HCLK);
    req = 1'b0;
    waitAck(1'b0, fall);
  endtask

  task automatic readCheck(input string tag, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    int r, f;
    applyStimulus(1'b1, a, 32'h0, rd, r, f);
    checkOutput(tag, rd, exp);
  endtask

  task automatic applyMeas(input logic [15:0] c);
    @(negedge HCLK);
    meas_cnt = c; meas_valid = 1'b1;
    @(negedge HCLK);
    meas_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    int r, f, u0, i0, lowcnt;

    HRESET = 1'b1; req = 1'b0; wrn = 1'b1; add = 2'd0; data = 32'h0;
    meas_cnt = 16'h0; meas_valid = 1'b0;
    repeat (3) @(negedge HCLK);
    checkOutput("rst_ack", {31'd0, ack}, 32'd0);
    checkOutput("rst_lock", {31'd0, lock}, 32'd0);
    checkOutput("rst_rdata", r_data, 32'd0);
    checkOutput("rst_pulses", {30'd0, cfg_upd, integ_load}, 32'd0);
    HRESET = 1'b0;
    @(negedge HCLK);
    checkOutput("rst_mult", {16'd0, cfg_mult}, 32'h05F5);
    checkOutput("rst_tol_gain", {24'd0, cfg_tol, cfg_gain}, 32'h27);
    checkOutput("rst_integ", {6'd0, cfg_integ}, 32'd0);

    applyStimulus(1'b1, 2'd1, 32'h0, rd, r, f);
    checkOutput("rd_cfg1_rst", rd, 32'h0000_05F5);
    checkOutput("rd_rise_lat", r, 32'd3);
    checkOutput("rd_fall_lat", f, 32'd3);
    readCheck("rd_cfg2_rst", 2'd2, 32'h0000_0247);
    readCheck("rd_integ_rst", 2'd3, 32'h0);

    u0 = upd_seen;
    applyStimulus(1'b0, 2'd1, 32'h8003_0100, rd, r, f);
    checkOutput("wr_cfg1_lat", r, 32'd3);
    checkOutput("wr_cfg1_rdata_kept", rd, 32'h0);
    checkOutput("wr_cfg1_upd", upd_seen - u0, 32'd1);
    checkOutput("cfg_mult", {16'd0, cfg_mult}, 32'h0100);
    checkOutput("cfg_div", {28'd0, cfg_div}, 32'd3);
    checkOutput("cfg_open_loop", {31'd0, cfg_open_loop}, 32'd1);
    readCheck("rd_cfg1", 2'd1, 32'h8003_0100);

    u0 = upd_seen; i0 = integ_seen;
    applyStimulus(1'b0, 2'd3, 32'hFFFF_FFFF, rd, r, f);
    checkOutput("wr_integ_load", integ_seen - i0, 32'd1);
    checkOutput("wr_integ_no_upd", upd_seen - u0, 32'd0);
    checkOutput("cfg_integ", {6'd0, cfg_integ}, 32'h03FF_FFFF);
    readCheck("rd_integ", 2'd3, 32'h03FF_FFFF);

    u0 = upd_seen; i0 = integ_seen;
    applyStimulus(1'b0, 2'd0, 32'h1234_5678, rd, r, f);
    checkOutput("wr_status_pulses", (upd_seen - u0) + (integ_seen - i0), 32'd0);
    readCheck("rd_status_zero", 2'd0, 32'h0);

    applyStimulus(1'b0, 2'd1, 32'h0000_03E8, rd, r, f);
    applyStimulus(1'b0, 2'd2, 32'h0000_0400, rd, r, f);
    checkOutput("cfg_tol4", {28'd0, cfg_tol}, 32'd4);
    for (int i = 1; i <= 8; i++) begin
      applyMeas(16'd1003);
      if (i == 7) checkOutput("lock_after7", {31'd0, lock}, 32'd0);
    end
    checkOutput("lock_after8", {31'd0, lock}, 32'd1);
    applyMeas(16'd1005);
    checkOutput("lock_lost", {31'd0, lock}, 32'd0);
    readCheck("rd_status", 2'd0, 32'h0000_03ED);

    for (int i = 1; i <= 8; i++) applyMeas(16'd996);
    checkOutput("lock_tol_edge", {31'd0, lock}, 32'd1);
    applyStimulus(1'b0, 2'd1, 32'h0000_03E8, rd, r, f);
    checkOutput("lock_clr_by_cfg1", {31'd0, lock}, 32'd0);
    readCheck("rd_status2", 2'd0, 32'h0000_03E4);

    applyStimulus(1'b0, 2'd1, 32'h8000_03E8, rd, r, f);
    for (int i = 1; i <= 8; i++) applyMeas(16'd1000);
    checkOutput("lock_open_loop", {31'd0, lock}, 32'd0);
    applyStimulus(1'b0, 2'd1, 32'h0000_03E8, rd, r, f);

    u0 = upd_seen; lowcnt = 0;
    @(negedge HCLK);
    wrn = 1'b0; add = 2'd2; data = 32'h0000_0555; req = 1'b1;
    waitAck(1'b1, r);
    checkOutput("hold_rise_lat", r, 32'd3);
    repeat (10) begin
      @(negedge HCLK);
      if (ack !== 1'b1) lowcnt++;
    end
    checkOutput("hold_ack_steady", lowcnt, 32'd0);
    checkOutput("hold_single_access", upd_seen - u0, 32'd1);
    req = 1'b0;
    waitAck(1'b0, f);
    checkOutput("hold_fall_lat", f, 32'd3);
    checkOutput("hold_gain", {28'd0, cfg_gain}, 32'd5);

    @(negedge HCLK);
    wrn = 1'b0; add = 2'd2; data = 32'h0000_0F0F; req = 1'b1;
    waitAck(1'b1, r);
    @(negedge HCLK);
    HRESET = 1'b1;
    @(negedge HCLK);
    checkOutput("mid_rst_ack", {31'd0, ack}, 32'd0);
    checkOutput("mid_rst_cfg2", {24'd0, cfg_tol, cfg_gain}, 32'h27);
    @(negedge HCLK);
    HRESET = 1'b0;
    waitAck(1'b1, r);
    checkOutput("post_rst_lat", r, 32'd3);
    checkOutput("post_rst_cfg2", {24'd0, cfg_tol, cfg_gain}, 32'hFF);
    @(negedge HCLK);
    req = 1'b0;
    waitAck(1'b0, f);
    checkOutput("post_rst_fall", f, 32'd3);
    readCheck("rd_cfg2_after_rst", 2'd2, 32'h0000_0F0F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fll_cfg_responder.md
Name: fll_cfg_responder

Overview:
FLL-side responder for the four-phase FLL configuration handshake (req/wrn/add/data -> ack/r_data) driven by the APB FLL interface. It runs in the FLL reference-clock domain and synchronises the incoming request. It holds the FLL configuration registers and executes register reads and writes. It also generates the lock indication that the APB side reads back through its lock synchroniser.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the req synchroniser (>=2)
CFG1_RST, 32'h0000_05F5, reset value of CFG1
CFG2_RST, 32'h0000_0247, reset value of CFG2
LOCK_CYCLES, 8, consecutive in-tolerance measurements required to assert lock (>=1)

Ports:
HCLK  in  1  FLL reference clock; all logic is on its rising edge
HRESET  in  1  asynchronous active-high reset
req  in  1  request from the initiator (asynchronous, level)
wrn  in  1  1 = read, 0 = write; stable while req is high
add  in  2  register address; stable while req is high
data  in  32  write data; stable while req is high
ack  out  1  acknowledge (registered)
r_data  out  32  read data (registered)
meas_cnt  in  16  DCO cycles counted per reference period
meas_valid  in  1  single-cycle strobe; meas_cnt is valid on this cycle
lock  out  1  lock indication (registered)
cfg_mult  out  16  CFG1[15:0] multiplication factor
cfg_div  out  4  CFG1[19:16] output clock divider
cfg_open_loop  out  1  CFG1[31]
cfg_gain  out  4  CFG2[3:0] loop gain
cfg_tol  out  4  CFG2[11:8] lock tolerance
cfg_integ  out  26  INTEG[25:0] integrator preload value
integ_load  out  1  one-cycle pulse on every write to INTEG
cfg_upd  out  1  one-cycle pulse on every write to CFG1 or CFG2

Behaviour:
- req passes through SYNC_STAGES flip-flops to give req_s. These flip-flops reset to 0.
- FSM has three states: IDLE, ACCESS, ACKED. It resets to IDLE.
- IDLE: if req_s = 1, go to ACCESS.
- ACCESS (exactly one cycle):
  - Sample add, wrn and data.
  - Read: r_data is loaded with the addressed register.
  - Write: the addressed register is updated; r_data is unchanged.
  - Go to ACKED; ack = 1 from the next edge.
- ACKED: ack is held at 1. When req_s = 0, ack clears at the next edge and the FSM returns to IDLE.
- A new request is accepted only after returning to IDLE. A req that re-rises while in ACKED is served on the next IDLE pass.
- Request-to-ack latency: SYNC_STAGES + 1 HCLK edges after req rises.
- r_data holds its value between reads.
- Register map:
  - add 0 STATUS (read-only): {15'b0, lock, last_meas[15:0]}. Writes are ignored, with no pulse and no error.
  - add 1 CFG1: RW, reset CFG1_RST. Bits not listed under Ports read back as written.
  - add 2 CFG2: RW, reset CFG2_RST.
  - add 3 INTEG: RW, bits [25:0] only, reset 0. Bits [31:26] read as 0.
- Pulses: integ_load and cfg_upd are high for exactly the cycle after ACCESS, together with the first ack = 1 cycle.
- last_meas: captures meas_cnt on every meas_valid. Reset value 0.
- Lock detector, evaluated on each meas_valid:
  - diff = |meas_cnt - cfg_mult|, computed 17-bit unsigned with no wrap.
  - If diff <= cfg_tol: the counter saturating-increments.
  - Otherwise: the counter clears and lock clears at the next edge.
  - lock is set when the counter reaches LOCK_CYCLES.
  - Any write to CFG1 clears the counter and lock.
  - If cfg_open_loop = 1, lock is forced to 0.
- Simultaneous events: a write to CFG1 in the same cycle as meas_valid evaluates against the old cfg_mult. The clear caused by the write then wins.
- Reset mid-transaction: all registers return to reset values, ack = 0, FSM = IDLE. A still-high req is re-served after reset is released.
- Reset values of outputs: ack 0, r_data 0, lock 0, integ_load 0, cfg_upd 0. Config outputs take the register reset values.

Decomposition:
- Package fll_cfg_pkg holds:
  - FSM state enum.
  - Address constants ADDR_STATUS = 0, ADDR_CFG1 = 1, ADDR_CFG2 = 2, ADDR_INTEG = 3.
  - Packed struct typedefs for CFG1 and CFG2.
  - Field reset defaults.
- One sub-module, fll_lock_detect, contains the tolerance compare, the saturating counter and the lock flag.

Test Plan:
- Reset -> ack = 0 and lock = 0. Read add 1 returns 0x0000_05F5, add 2 returns 0x0000_0247, add 3 returns 0.
- Write add 1 with 0x8003_0100, then read it back -> r_data = 0x8003_0100. cfg_mult = 0x0100, cfg_div = 3, cfg_open_loop = 1. cfg_upd pulses once. ack rises 3 edges after req.
- Write add 3 with 0xFFFF_FFFF -> integ_load pulses once. Readback = 0x03FF_FFFF.
- Set cfg_mult = 1000, cfg_tol = 4, open_loop = 0. Apply 8 meas_valid strobes with meas_cnt = 1003 -> lock = 1 after the 8th. One strobe with 1005 -> lock = 0. STATUS read returns 0x0000_03ED.
- Hold req high for 10 cycles after ack -> ack stays 1 and there is no second access. Drop req -> ack = 0 three edges later.
- Assert HRESET while in ACKED with a write pending on CFG2 -> ack = 0 and CFG2 = 0x0000_0247. With req still high after reset release, the access completes normally.
